muldiv_hilo: RTL and testbench

- Multi-cycle unsigned multiply/divide unit with architectural HI/LO registers for the single-cycle CPU.
- Sits on the opposite side of the ALU result/result2 path. It takes the ALU's sel=3 (MUL) and sel=4 (DIV) work off the combinational path. It writes the 64-bit outcome into HI/LO, which the datapath then reads back (mfhi/mflo) or writes directly (mthi/mtlo).
- Result mapping is the same as the ALU: LO=low product / quotient, HI=high product / remainder.

---
 rtl/muldiv_hilo_pkg.sv | 21 ++
 rtl/muldiv_hilo_if.sv | 27 ++
 rtl/muldiv_hilo_iter.sv | 38 +++
 rtl/muldiv_hilo.sv | 115 +++++++++++
 tb/tb_muldiv_hilo.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/muldiv_hilo_pkg.sv
// rtl/muldiv_hilo_pkg.sv - shared op/state/sel encodings for the mul/div unit
package muldiv_hilo_pkg;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [3:0] SEL_MUL = 4'd3;
  localparam logic [3:0] SEL_DIV = 4'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Decoder helper: ALU sel code to mul/div op (only meaningful for SEL_MUL/SEL_DIV)
  function automatic logic sel_to_op(input logic [3:0] sel);
    return (sel == SEL_DIV) ? OP_DIV : OP_MUL;
  endfunction

endpackage

// File: rtl/muldiv_hilo_if.sv
// rtl/muldiv_hilo_if.sv - CPU-side request, direct-write and HI/LO read bundle
interface muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic             dz;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, x, y, hi_we, lo_we, wdata,
    input  busy, done, dz, hi, lo
  );

  modport slave (
    input  start, op, x, y, hi_we, lo_we, wdata,
    output busy, done, dz, hi, lo
  );
endinterface

// File: rtl/muldiv_hilo_iter.sv
// rtl/muldiv_hilo_iter.sv - one shift-add multiply or restoring divide step
module muldiv_hilo_iter
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               op,
  input  logic [2*WIDTH:0]   wr,       // MUL: {0, acc_hi, acc_lo}; DIV: {rem, quot}
  input  logic [WIDTH-1:0]   operand,  // MUL: multiplicand; DIV: divisor
  output logic [2*WIDTH:0]   nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH+1:0] rem_wide;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] quot_s;

  // Multiply: conditional add into the upper half, carry kept for the right shift
  assign sum = {1'b0, wr[2*WIDTH-1:WIDTH]} + (wr[0] ? {1'b0, operand} : '0);

  // Divide: shift {rem,quot} left; an extra top bit keeps the trial sign exact
  assign rem_wide = {wr[2*WIDTH:WIDTH], wr[WIDTH-1]};
  assign quot_s   = {wr[WIDTH-2:0], 1'b0};
  assign trial    = rem_wide - {2'b00, operand};

  // Select the step result for the active op
  always_comb begin
    nxt = wr;
    if (op == OP_MUL) begin
      nxt = {1'b0, sum, wr[WIDTH-1:1]};
    end else if (!trial[WIDTH+1]) begin
      nxt = {trial[WIDTH:0], quot_s[WIDTH-1:1], 1'b1};
    end else begin
      nxt = {rem_wide[WIDTH:0], quot_s};
    end
  end

endmodule

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - multi-cycle unsigned mul/div with architectural HI/LO
module muldiv_hilo
  import muldiv_hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_hilo_if.slave  bus
);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               op_q;
  logic [WIDTH-1:0]   operand;
  logic [2*WIDTH:0]   wr;
  logic [2*WIDTH:0]   wr_nxt;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               dz_q;
  logic               busy_q;
  logic               done_q;
  logic               accept;
  logic               last;

  assign accept = (state == IDLE) && bus.start;
  assign last   = (cnt == CNT_W'(WIDTH - 1));

  muldiv_hilo_iter #(.WIDTH(WIDTH)) u_iter (
    .op      (op_q),
    .wr      (wr),
    .operand (operand),
    .nxt     (wr_nxt)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: accept in IDLE, run WIDTH steps, one DONE cycle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:                   state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  // Operand capture at acceptance, then one datapath step per RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      op_q    <= OP_MUL;
      operand <= '0;
      wr      <= '0;
    end else if (accept) begin
      cnt  <= '0;
      op_q <= bus.op;
      if (bus.op == OP_DIV) begin
        operand <= bus.y;
        wr      <= {{(WIDTH+1){1'b0}}, bus.x};
      end else begin
        operand <= bus.x;
        wr      <= {{(WIDTH+1){1'b0}}, bus.y};
      end
    end else if (state == RUN) begin
      wr  <= wr_nxt;
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Divide-by-zero flag, re-evaluated at every accepted start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      dz_q <= 1'b0;
    else if (accept) dz_q <= (bus.op == OP_DIV) && (bus.y == '0);
  end

  // HI/LO: result load leaving DONE, direct writes only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (state == DONE) begin
      hi_q <= wr[2*WIDTH-1:WIDTH];
      lo_q <= wr[WIDTH-1:0];
    end else if (state == IDLE) begin
      if (bus.hi_we) hi_q <= bus.wdata;
      if (bus.lo_we) lo_q <= bus.wdata;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dz   = dz_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - randomized self-checking bench for muldiv_hilo
module tb_muldiv_hilo;
  import muldiv_hilo_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  muldiv_hilo_if #(.WIDTH(32)) mif ();

  muldiv_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
  endtask

  // inj: 0 none, 1 start(DIV 9/3) during RUN, 2 hi_we(0x1234) during RUN
  task automatic do_op(input logic o, input logic [31:0] a, input logic [31:0] b, input int inj);
    int          cyc;
    int          dones;
    int          done_at;
    logic [63:0] prod;
    logic [31:0] ehi;
    logic [31:0] elo;
    if (o == OP_MUL) begin
      prod = {32'b0, a} * {32'b0, b};
      ehi  = prod[63:32];
      elo  = prod[31:0];
    end else if (b == 32'd0) begin
      ehi = a;
      elo = 32'hFFFF_FFFF;
    end else begin
      ehi = a % b;
      elo = a / b;
    end
    @(negedge clk);
    mif.start = 1'b1; mif.op = o; mif.x = a; mif.y = b;
    @(negedge clk);
    mif.start = 1'b0; mif.x = $urandom; mif.y = $urandom;
    cyc = 0; dones = 0; done_at = -1;
    while (mif.busy && cyc < 100) begin
      if (mif.done) begin
        dones++;
        done_at = cyc;
      end
      if (cyc == 10 && inj == 1) begin
        mif.start = 1'b1; mif.op = OP_DIV; mif.x = 32'd9; mif.y = 32'd3;
      end else if (cyc == 10 && inj == 2) begin
        mif.hi_we = 1'b1; mif.wdata = 32'h1234;
      end else begin
        mif.start = 1'b0; mif.hi_we = 1'b0;
      end
      cyc++;
      @(negedge clk);
    end
    mif.start = 1'b0; mif.hi_we = 1'b0;
    check("busy_cycles", 64'(cyc), 64'd33);
    check("done_count", 64'(dones), 64'd1);
    check("done_at", 64'(done_at), 64'd32);
    check("hi", {32'b0, mif.hi}, {32'b0, ehi});
    check("lo", {32'b0, mif.lo}, {32'b0, elo});
    check("dz", {63'b0, mif.dz}, {63'b0, (o == OP_DIV) && (b == 32'd0)});
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          dn;
    n_checks = 0; n_pass = 0;
    rst_n = 1'b0;
    mif.start = 1'b0; mif.op = OP_MUL; mif.x = '0; mif.y = '0;
    mif.hi_we = 1'b0; mif.lo_we = 1'b0; mif.wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, mif.busy}, 64'd0);
    check("rst_done", {63'b0, mif.done}, 64'd0);
    check("rst_dz", {63'b0, mif.dz}, 64'd0);
    check("rst_hi", {32'b0, mif.hi}, 64'd0);
    check("rst_lo", {32'b0, mif.lo}, 64'd0);
    rst_n = 1'b1;

    do_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_op(OP_DIV, 32'd100, 32'd7, 0);
    do_op(OP_DIV, 32'd5, 32'd0, 0);
    do_op(OP_MUL, 32'd6, 32'd7, 0);
    do_op(OP_MUL, 32'd3, 32'd4, 1);

    // Direct LO write while idle
    @(negedge clk);
    mif.lo_we = 1'b1; mif.wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mif.lo_we = 1'b0;
    check("lo_direct", {32'b0, mif.lo}, 64'hDEAD_BEEF);
    @(negedge clk);
    mif.hi_we = 1'b1; mif.lo_we = 1'b1; mif.wdata = 32'hCAFE_0001;
    @(negedge clk);
    mif.hi_we = 1'b0; mif.lo_we = 1'b0;
    check("hi_both", {32'b0, mif.hi}, 64'hCAFE_0001);
    check("lo_both", {32'b0, mif.lo}, 64'hCAFE_0001);

    // HI write during RUN is ignored
    do_op(OP_MUL, 32'h0001_0000, 32'h0003_0000, 2);

    // Reset mid-operation
    @(negedge clk);
    mif.start = 1'b1; mif.op = OP_DIV; mif.x = 32'd1000; mif.y = 32'd10;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {63'b0, mif.busy}, 64'd0);
    check("mid_rst_hi", {32'b0, mif.hi}, 64'd0);
    check("mid_rst_lo", {32'b0, mif.lo}, 64'd0);
    dn = 0;
    repeat (3) begin
      @(negedge clk);
      if (mif.done) dn++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (mif.done) dn++;
    end
    check("mid_rst_no_done", 64'(dn), 64'd0);
    check("mid_rst_idle", {63'b0, mif.busy}, 64'd0);
    do_op(OP_DIV, 32'd1000, 32'd10, 0);

    // Random MUL/DIV pairs with nonzero divisor
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      rb = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 255));
      if (rb == 32'd0) rb = 32'd1;
      do_op(OP_MUL, ra, rb, 0);
      do_op(OP_DIV, ra, rb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
